// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) supplies decode fields, branch resolution and
// memory readiness; the controller side (slave) returns stall, flush,
// forward selects and status.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             RegWriteD;
  logic             MemWriteD;
  logic [1:0]       ResultSrcD;
  logic             PCSrcE;
  logic             MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [CNT_W-1:0] StallCount;
  logic             MemTimeout;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD, PCSrcE, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, Rs1E, Rs2E, StallCount, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD, PCSrcE, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, Rs1E, Rs2E, StallCount, MemTimeout
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage pipeline. Tracks a shadow copy of the
// E/M/W register fields it needs, resolves load-use and memory-wait stalls,
// branch flushes and operand forwarding, and keeps a stall performance
// counter plus a sticky memory-timeout flag.
module hazard_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input logic   clk,
  input logic   rst,
  hazard_if.slave hz
);

  localparam logic [7:0] TMO     = 8'(TIMEOUT);
  localparam logic [7:0] TMO_M1  = 8'(TIMEOUT - 1);

  // E-stage shadow
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       regwrite_e;
  logic [1:0] resultsrc_e;
  logic       mem_e;
  // M-stage shadow; the M result source has no consumer in this block, load-ness
  // in M is already carried by mem_m.
  logic [4:0] rd_m;
  logic       regwrite_m;
  logic       mem_m;
  // W-stage shadow
  logic [4:0] rd_w;
  logic       regwrite_w;

  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  logic mem_d;
  logic mem_stall;
  logic lw_stall;
  logic flush_e;

  assign mem_d     = hz.MemWriteD | (hz.ResultSrcD == 2'b01);
  assign mem_stall = mem_m & ~hz.MemReadyM;
  assign lw_stall  = (resultsrc_e == 2'b01) & regwrite_e & (rd_e != 5'd0) &
                     ((rd_e == hz.Rs1D) | (rd_e == hz.Rs2D));
  // A memory wait freezes everything, so the E bubble only applies without it.
  assign flush_e   = ~mem_stall & (lw_stall | hz.PCSrcE);

  assign hz.Rs1E       = rs1_e;
  assign hz.Rs2E       = rs2_e;
  assign hz.StallCount = stall_cnt;
  assign hz.MemTimeout = mem_timeout;

  // Stall and flush decode; memory wait dominates load-use and branch flush.
  always_comb begin
    // NOTE: every output is given a default first so no path can infer a latch.
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else begin
        hz.StallF = lw_stall;
        hz.StallD = lw_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall | hz.PCSrcE;
      end
    end
  end

  // Forward selects: the younger M result wins over W; x0 is never forwarded.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (rst) begin
      if (regwrite_m && rd_m != 5'd0 && rd_m == rs1_e)      hz.ForwardAE = 2'b10;
      else if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_e) hz.ForwardAE = 2'b01;
      if (regwrite_m && rd_m != 5'd0 && rd_m == rs2_e)      hz.ForwardBE = 2'b10;
      else if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_e) hz.ForwardBE = 2'b01;
    end
  end

  // Shadow pipeline advance: hold E/M and bubble W on a memory wait.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is written with non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    if (!rst) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      regwrite_e  <= 1'b0;
      resultsrc_e <= '0;
      mem_e       <= 1'b0;
      rd_m        <= '0;
      regwrite_m  <= 1'b0;
      mem_m       <= 1'b0;
      rd_w        <= '0;
      regwrite_w  <= 1'b0;
    end else if (mem_stall) begin
      rd_w       <= '0;
      regwrite_w <= 1'b0;
    end else begin
      if (flush_e) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        regwrite_e  <= 1'b0;
        resultsrc_e <= '0;
        mem_e       <= 1'b0;
      end else begin
        rs1_e       <= hz.Rs1D;
        rs2_e       <= hz.Rs2D;
        rd_e        <= hz.RdD;
        regwrite_e  <= hz.RegWriteD;
        resultsrc_e <= hz.ResultSrcD;
        mem_e       <= mem_d;
      end
      rd_m       <= rd_e;
      regwrite_m <= regwrite_e;
      mem_m      <= mem_e;
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m;
    end
  end

  // Memory wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (!mem_stall)          wait_cnt <= '0;
      else if (wait_cnt != TMO) wait_cnt <= wait_cnt + 8'd1;

      if (mem_stall && wait_cnt == TMO_M1) mem_timeout <= 1'b1;

      if ((lw_stall || mem_stall) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a table of per-cycle decode
// inputs with hand-derived expected control outputs, plus hand-written
// sequences for memory wait, timeout and reset mid-stall.
module tb_hazard_controller;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CNT_W)) hz ();

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rsrc;
    logic        pcsrc;
    logic        ready;
    logic [10:0] exp;   // {sf,sd,se,sm,fd,fe,fw,fa[1:0],fb[1:0]}
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int sc_model = 0;
  logic [10:0] exp_q[$];
  vec_t tbl[$];

  function automatic logic [10:0] ex(input logic sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs1, rs2, rd, input logic rw, mw,
                              input logic [1:0] rsrc, input logic pcsrc, ready,
                              input logic [10:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.mw = mw;
    v.rsrc = rsrc; v.pcsrc = pcsrc; v.ready = ready; v.exp = exp;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
            hz.FlushW, hz.ForwardAE, hz.ForwardBE};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.Rs1D = v.rs1; hz.Rs2D = v.rs2; hz.RdD = v.rd;
    hz.RegWriteD = v.rw; hz.MemWriteD = v.mw; hz.ResultSrcD = v.rsrc;
    hz.PCSrcE = v.pcsrc; hz.MemReadyM = v.ready;
  endtask

  // Drives one cycle of inputs, compares outputs at the falling edge, then
  // lets the rising edge commit. Entered and left 1 time unit after posedge.
  task automatic apply_vec(input vec_t v, input string name);
    logic [10:0] want;
    drive(v);
    exp_q.push_back(v.exp);
    if (v.exp[10] && sc_model < 65535) sc_model++;
    @(negedge clk);
    want = exp_q.pop_front();
    check(name, 32'(outs()), 32'(want));
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] z, lws, mst;
    vec_t nop, sw;
    z   = '0;
    lws = ex(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00);
    mst = ex(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00);
    nop = mk(0, 0, 0, 0, 0, 2'b00, 0, 1, z);
    sw  = mk(1, 2, 0, 0, 1, 2'b00, 0, 1, z);

    // Load-use: lw x5, then a consumer of x5 held one cycle in D
    tbl.push_back(mk(1, 0, 5, 1, 0, 2'b01, 0, 1, z));
    tbl.push_back(mk(5, 0, 6, 1, 0, 2'b00, 0, 1, lws));
    tbl.push_back(mk(5, 0, 6, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00)));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // ALU hazard: back-to-back, one apart, and via x0
    tbl.push_back(mk(1, 2, 3, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(4, 3, 7, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10)));
    tbl.push_back(mk(1, 2, 3, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(1, 1, 8, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(4, 3, 7, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)));
    tbl.push_back(mk(1, 2, 0, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(mk(4, 0, 7, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(nop);   // M writes x0, E reads x0: no forward
    tbl.push_back(nop);   // W writes x0: no forward
    tbl.push_back(nop);
    // Load to x0 followed by a reader of x0: no stall, no forward
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'b01, 0, 1, z));
    tbl.push_back(mk(0, 0, 9, 1, 0, 2'b00, 0, 1, z));
    tbl.push_back(nop);
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Branch in the same cycle as a load-use
    tbl.push_back(mk(1, 0, 5, 1, 0, 2'b01, 0, 1, z));
    tbl.push_back(mk(5, 0, 6, 1, 0, 2'b00, 1, 1, ex(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00)));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Branch alone
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, ex(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00)));
    tbl.push_back(nop);

    // Reset: outputs forced low even with a branch and memory not ready
    drive(mk(0, 0, 0, 0, 0, 2'b00, 1, 0, z));
    #12;
    check("reset_outputs", 32'(outs()), 32'(z));
    check("reset_status", {hz.Rs1E, hz.Rs2E, hz.MemTimeout, 16'(hz.StallCount)}, 32'd0);
    drive(nop);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // E source fields are tracked
    apply_vec(mk(11, 12, 0, 0, 0, 2'b00, 0, 1, z), "track_in");
    check("rs1_e", 32'(hz.Rs1E), 32'd11);
    check("rs2_e", 32'(hz.Rs2E), 32'd12);

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));
    check("stall_count_table", 32'(hz.StallCount), 32'(sc_model));

    // Store waits 3 cycles in M; a branch during the wait is ignored
    apply_vec(sw, "mw_store");
    apply_vec(nop, "mw_nop");
    apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, mst), "mw_wait1");
    apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 1, 0, mst), "mw_wait2_branch");
    apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, mst), "mw_wait3");
    apply_vec(nop, "mw_done");
    check("stall_count_memwait", 32'(hz.StallCount), 32'(sc_model));
    check("no_timeout_short_wait", 32'(hz.MemTimeout), 32'd0);

    // Memory held not ready for 20 cycles
    apply_vec(sw, "to_store");
    apply_vec(nop, "to_nop");
    for (int i = 0; i < 20; i++) begin
      apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, mst), $sformatf("to_wait%0d", i + 1));
      check($sformatf("timeout_after_%0d", i + 1), 32'(hz.MemTimeout),
            32'((i + 1) >= TIMEOUT));
    end
    apply_vec(nop, "to_ready");
    apply_vec(nop, "to_after");
    check("timeout_sticky", 32'(hz.MemTimeout), 32'd1);
    check("stall_count_timeout", 32'(hz.StallCount), 32'(sc_model));

    // Reset in the middle of a memory wait
    apply_vec(sw, "rs_store");
    apply_vec(nop, "rs_nop");
    apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, mst), "rs_wait1");
    drive(mk(0, 0, 0, 0, 0, 2'b00, 1, 0, z));
    rst = 1'b0;
    #1;
    check("midstall_reset_outputs", 32'(outs()), 32'(z));
    check("midstall_reset_timeout", 32'(hz.MemTimeout), 32'd0);
    check("midstall_reset_count", 32'(hz.StallCount), 32'd0);
    sc_model = 0;
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, z));
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Empty pipeline after release: memory not ready causes no stall
    apply_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, z), "resume_empty");
    check("resume_count", 32'(hz.StallCount), 32'(sc_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the number of memory wait cycles before MemTimeout asserts (range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the stall performance counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
REQ-004 The block SHALL have these D-stage inputs:
- Rs1D, Rs2D, RdD  input  5 each  decode-stage register fields
- RegWriteD  input  1  decode instruction writes rd
- MemWriteD  input  1  decode instruction is a store
- ResultSrcD  input  2  00 ALU, 01 load, 10 PC+4
REQ-005 The block SHALL have these other inputs:
- PCSrcE  input  1  taken branch or jump resolved in E
- MemReadyM  input  1  data memory completes the M-stage access this cycle
REQ-006 The block SHALL have these control outputs:
- StallF, StallD, StallE, StallM  output  1 each  hold the stage register
- FlushD, FlushE, FlushW  output  1 each  clear the stage register to a bubble
- ForwardAE, ForwardBE  output  2 each  00 register file, 01 W result, 10 M ALU result
REQ-007 The block SHALL have these status outputs:
- Rs1E, Rs2E  output  5 each  tracked E-stage source fields
- StallCount  output  CNT_W  saturating count of lw/mem stall cycles
- MemTimeout  output  1  sticky timeout flag

Function
REQ-008 The block SHALL keep shadow pipeline registers: E {Rs1, Rs2, Rd, RegWrite, ResultSrc, Mem}, M {Rd, RegWrite, ResultSrc, Mem}, W {Rd, RegWrite}. Mem is 1 when the instruction is a load or a store.
REQ-009 memStall SHALL be MemM & ~MemReadyM.
REQ-010 lwStall SHALL be (ResultSrcE==01) & RegWriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-011 When memStall=1, the outputs SHALL be StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=0 and FlushE=0; PCSrcE and lwStall are ignored that cycle.
REQ-012 When memStall=0, StallF=StallD=lwStall, StallE=StallM=FlushW=0, FlushD=PCSrcE and FlushE=lwStall|PCSrcE.
REQ-013 Shadow update on each clock edge SHALL be:
- if memStall: E and M hold, W loads a bubble (all fields 0);
- otherwise E loads the D inputs, or a bubble when FlushE=1; M loads E; W loads M.
REQ-014 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E. M priority over W is mandatory.
REQ-015 All stall, flush and forward outputs SHALL be combinational from shadow state and current inputs, with zero-cycle latency.
REQ-016 The wait counter (8 bit) SHALL increment each memStall cycle, saturate at TIMEOUT, and clear to 0 on any cycle with memStall=0.
REQ-017 MemTimeout SHALL set on the edge where memStall=1 and the wait counter equals TIMEOUT-1, and SHALL clear only by reset; the pipeline keeps stalling while memory is not ready.
REQ-018 StallCount SHALL increment on each edge where lwStall|memStall=1 and SHALL saturate at all-ones.
REQ-019 A load writing x0 SHALL never cause lwStall or forwarding.

Reset
REQ-020 While rst=0, all shadow registers, the wait counter, StallCount and MemTimeout SHALL be 0 asynchronously.
REQ-021 While rst=0, all stall, flush and forward outputs SHALL be forced to 0 regardless of PCSrcE and MemReadyM.
REQ-022 Reset asserted mid-stall SHALL abandon the stall; after release the block SHALL resume with an empty pipeline.

Verification
REQ-023 Load-use: load x5 (ResultSrcD=01, RdD=5) then Rs1D=5 next cycle -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01 in the following E cycle.
REQ-024 ALU hazard: add x3, then sub using Rs2D=3 -> ForwardBE=10 in the consumer's E cycle; with one independent instruction between -> ForwardBE=01; with RdD=0 -> ForwardBE=00.
REQ-025 Branch with simultaneous load-use: PCSrcE=1 in the same cycle as lwStall -> FlushD=1, FlushE=1, StallF=1; next cycle no stall.
REQ-026 Memory wait: store reaches M with MemReadyM=0 for 3 cycles -> StallF..StallM=1 and FlushW=1 for 3 cycles, PCSrcE=1 during the wait is ignored, StallCount +3.
REQ-027 Timeout: MemReadyM held 0 for 20 cycles with TIMEOUT=15 -> MemTimeout rises after the 15th stall cycle and stays 1 after MemReadyM=1; rst low -> MemTimeout=0 and all outputs 0 immediately.
